// File: rtl/ntt_dma_pkg.sv
// Shared types and constants for the NTT DMA client port.
package ntt_dma_pkg;

    localparam int unsigned ADDR_W     = 48;
    localparam int unsigned LEN_W      = 32;
    localparam int unsigned CMD_TAG_W  = 4;
    localparam int unsigned WORD_BYTES = 8;

    // One queued transfer command; tag field sized for the default tag width.
    typedef struct packed {
        logic                 rw;
        logic [ADDR_W-1:0]    addr;
        logic [LEN_W-1:0]     len;
        logic [CMD_TAG_W-1:0] tag;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/ntt_dma_cmd_fifo.sv
// Synchronous command FIFO; push while full is accepted when a pop happens in the same cycle.
module ntt_dma_cmd_fifo
    import ntt_dma_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  cmd_t i_data,
    input  logic i_pop,
    output cmd_t o_data,
    output logic o_full,
    output logic o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    cmd_t          r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic          w_do_push;
    logic          w_do_pop;

    // Extra pointer bit separates the full and empty cases.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; reset empties the queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    // Storage array, written on accepted push only.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/ntt_dma_port.sv
// Client-side DMA sequencer: queues commands and splits them into arbiter bursts.
module ntt_dma_port
    import ntt_dma_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned MAX_BURST = 1024,
    parameter int unsigned TAG_W     = CMD_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_rw,
    input  logic [47:0]      cmd_addr,
    input  logic [31:0]      cmd_len,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic             mem_req,
    output logic             mem_rw,
    output logic [47:0]      mem_addr,
    output logic [31:0]      mem_len,
    output logic [31:0]      mem_off,
    input  logic             mem_ack,
    output logic             done_valid,
    output logic [TAG_W-1:0] done_tag,
    output logic             done_rw,
    output logic             busy
);

    localparam logic [LEN_W-1:0] MAX_BURST_L = LEN_W'(MAX_BURST);

    state_t             r_state;
    logic [ADDR_W-1:0]  r_cur_addr;
    logic [LEN_W-1:0]   r_remaining;
    logic [LEN_W-1:0]   r_off;
    logic [LEN_W-1:0]   r_chunk;
    logic               r_rw;
    logic [TAG_W-1:0]   r_tag;
    logic               r_req_q;
    logic               r_mem_rw;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [LEN_W-1:0]   r_mem_len;
    logic [LEN_W-1:0]   r_mem_off;
    logic               r_done_valid;
    logic [TAG_W-1:0]   r_done_tag;
    logic               r_done_rw;

    cmd_t               w_cmd_in;
    cmd_t               w_rd;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic [LEN_W-1:0]   w_chunk;
    logic [LEN_W-1:0]   w_rem_next;
    logic [ADDR_W-1:0]  w_addr_step;

    // Pack the incoming command for the queue.
    always_comb begin
        w_cmd_in      = '0;
        w_cmd_in.rw   = cmd_rw;
        w_cmd_in.addr = cmd_addr;
        w_cmd_in.len  = cmd_len;
        w_cmd_in.tag  = CMD_TAG_W'(cmd_tag);
    end

    assign w_push = cmd_valid && !w_full;
    assign w_pop  = (r_state == IDLE) && !w_empty;

    ntt_dma_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_cmd_in),
        .i_pop   (w_pop),
        .o_data  (w_rd),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_chunk     = (r_remaining < MAX_BURST_L) ? r_remaining : MAX_BURST_L;
    assign w_rem_next  = r_remaining - r_chunk;
    assign w_addr_step = ADDR_W'(r_chunk) * ADDR_W'(WORD_BYTES);

    // Burst sequencer: one command in flight, bursts of at most MAX_BURST words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cur_addr   <= '0;
            r_remaining  <= '0;
            r_off        <= '0;
            r_chunk      <= '0;
            r_rw         <= 1'b0;
            r_tag        <= '0;
            r_req_q      <= 1'b0;
            r_mem_rw     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_len    <= '0;
            r_mem_off    <= '0;
            r_done_valid <= 1'b0;
            r_done_tag   <= '0;
            r_done_rw    <= 1'b0;
        end else begin
            r_done_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_cur_addr  <= w_rd.addr;
                        r_remaining <= w_rd.len;
                        r_off       <= '0;
                        r_rw        <= w_rd.rw;
                        r_tag       <= TAG_W'(w_rd.tag);
                        r_state     <= LOAD;
                    end
                end
                LOAD: begin
                    if (r_remaining == '0) begin
                        r_done_valid <= 1'b1;
                        r_done_tag   <= r_tag;
                        r_done_rw    <= r_rw;
                        r_state      <= DONE;
                    end else begin
                        r_chunk    <= w_chunk;
                        r_mem_addr <= r_cur_addr;
                        r_mem_len  <= w_chunk;
                        r_mem_off  <= r_off;
                        r_mem_rw   <= r_rw;
                        r_req_q    <= 1'b1;
                        r_state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        r_req_q     <= 1'b0;
                        r_cur_addr  <= r_cur_addr + w_addr_step;
                        r_off       <= r_off + r_chunk;
                        r_remaining <= w_rem_next;
                        if (w_rem_next == '0) begin
                            r_done_valid <= 1'b1;
                            r_done_tag   <= r_tag;
                            r_done_rw    <= r_rw;
                            r_state      <= DONE;
                        end else begin
                            r_state <= LOAD;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Request drops in the ack cycle so the arbiter cannot re-grant the same burst.
    assign mem_req    = r_req_q & ~mem_ack;
    assign mem_rw     = r_mem_rw;
    assign mem_addr   = r_mem_addr;
    assign mem_len    = r_mem_len;
    assign mem_off    = r_mem_off;
    assign done_valid = r_done_valid;
    assign done_tag   = r_done_tag;
    assign done_rw    = r_done_rw;
    assign cmd_ready  = !w_full;
    assign busy       = !w_empty || (r_state != IDLE);

endmodule

// File: tb/tb_ntt_dma_port.sv
// Directed bench for ntt_dma_port: burst splitting, ordering, backpressure, wrap and reset.
module tb_ntt_dma_port;

    logic        clk;
    logic        rst;
    logic        sel;
    logic        cmd_valid;
    logic        cmd_rw;
    logic [47:0] cmd_addr;
    logic [31:0] cmd_len;
    logic [3:0]  cmd_tag;
    logic        mem_ack;

    logic        a_cmd_ready, a_mem_req, a_mem_rw, a_done_valid, a_done_rw, a_busy;
    logic [47:0] a_mem_addr;
    logic [31:0] a_mem_len, a_mem_off;
    logic [3:0]  a_done_tag;
    logic        b_cmd_ready, b_mem_req, b_mem_rw, b_done_valid, b_done_rw, b_busy;
    logic [47:0] b_mem_addr;
    logic [31:0] b_mem_len, b_mem_off;
    logic [3:0]  b_done_tag;

    logic        cmd_ready, mem_req, mem_rw, done_valid, done_rw, busy;
    logic [47:0] mem_addr;
    logic [31:0] mem_len, mem_off;
    logic [3:0]  done_tag;

    int n_pass = 0;
    int n_chk  = 0;
    int done_cnt = 0;
    int burst_cnt = 0;
    int acc_cnt = 0;
    int hold_target = 0;
    logic prev_req = 1'b0;
    logic [3:0] done_tag_q [$];
    logic       done_rw_q  [$];

    // sel=0 drives the MAX_BURST=1024 instance, sel=1 the MAX_BURST=256 instance.
    ntt_dma_port #(.DEPTH(4), .MAX_BURST(1024), .TAG_W(4)) u_a (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid & ~sel), .cmd_ready(a_cmd_ready),
        .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_tag(cmd_tag),
        .mem_req(a_mem_req), .mem_rw(a_mem_rw), .mem_addr(a_mem_addr), .mem_len(a_mem_len),
        .mem_off(a_mem_off), .mem_ack(mem_ack & ~sel), .done_valid(a_done_valid),
        .done_tag(a_done_tag), .done_rw(a_done_rw), .busy(a_busy)
    );

    ntt_dma_port #(.DEPTH(4), .MAX_BURST(256), .TAG_W(4)) u_b (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid & sel), .cmd_ready(b_cmd_ready),
        .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_tag(cmd_tag),
        .mem_req(b_mem_req), .mem_rw(b_mem_rw), .mem_addr(b_mem_addr), .mem_len(b_mem_len),
        .mem_off(b_mem_off), .mem_ack(mem_ack & sel), .done_valid(b_done_valid),
        .done_tag(b_done_tag), .done_rw(b_done_rw), .busy(b_busy)
    );

    assign cmd_ready  = sel ? b_cmd_ready  : a_cmd_ready;
    assign mem_req    = sel ? b_mem_req    : a_mem_req;
    assign mem_rw     = sel ? b_mem_rw     : a_mem_rw;
    assign mem_addr   = sel ? b_mem_addr   : a_mem_addr;
    assign mem_len    = sel ? b_mem_len    : a_mem_len;
    assign mem_off    = sel ? b_mem_off    : a_mem_off;
    assign done_valid = sel ? b_done_valid : a_done_valid;
    assign done_tag   = sel ? b_done_tag   : a_done_tag;
    assign done_rw    = sel ? b_done_rw    : a_done_rw;
    assign busy       = sel ? b_busy       : a_busy;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Record completions and count distinct burst requests.
    always @(negedge clk) begin
        if (done_valid) begin
            done_cnt++;
            done_tag_q.push_back(done_tag);
            done_rw_q.push_back(done_rw);
        end
        if (mem_req && !prev_req) burst_cnt++;
        prev_req = mem_req;
    end

    // Count accepted commands.
    always @(posedge clk) begin
        if (!rst && cmd_valid && cmd_ready) acc_cnt++;
    end

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", nm, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
        if (cmd_valid && hold_target > 0 && acc_cnt >= hold_target) cmd_valid = 1'b0;
    endtask

    task automatic push(input logic rw, input logic [47:0] addr, input logic [31:0] len,
                        input logic [3:0] tag);
        cmd_rw = rw; cmd_addr = addr; cmd_len = len; cmd_tag = tag;
        cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !cmd_ready; i++) step();
        chk("push_ready", 64'(cmd_ready), 64'd1);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic serve(input string nm, input logic [47:0] ea, input logic [31:0] el,
                         input logic [31:0] eo, input logic erw);
        for (int i = 0; i < 60 && !mem_req; i++) step();
        chk({nm, "_req"},  64'(mem_req),  64'd1);
        chk({nm, "_addr"}, 64'(mem_addr), 64'(ea));
        chk({nm, "_len"},  64'(mem_len),  64'(el));
        chk({nm, "_off"},  64'(mem_off),  64'(eo));
        chk({nm, "_rw"},   64'(mem_rw),   64'(erw));
        step();
        chk({nm, "_hold"}, 64'(mem_addr), 64'(ea));
        mem_ack = 1'b1;
        #1;
        chk({nm, "_req_low_in_ack"}, 64'(mem_req), 64'd0);
        step();
        mem_ack = 1'b0;
    endtask

    task automatic chk_done(input string nm, input logic [3:0] etag, input logic erw);
        logic [3:0] t;
        logic       r;
        t = 4'bx;
        r = 1'bx;
        if (done_tag_q.size() > 0) begin
            t = done_tag_q.pop_front();
            r = done_rw_q.pop_front();
        end
        chk({nm, "_tag"}, 64'(t), 64'(etag));
        chk({nm, "_rw"},  64'(r), 64'(erw));
    endtask

    initial begin
        int d0, b0, a0;
        rst = 1'b1; sel = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0;
        cmd_addr = '0; cmd_len = '0; cmd_tag = '0; mem_ack = 1'b0;

        // Reset state
        step(); step();
        chk("rst_mem_req",    64'(mem_req),    64'd0);
        chk("rst_cmd_ready",  64'(cmd_ready),  64'd1);
        chk("rst_busy",       64'(busy),       64'd0);
        chk("rst_done_valid", 64'(done_valid), 64'd0);
        chk("rst_mem_addr",   64'(mem_addr),   64'd0);
        rst = 1'b0;
        step();

        // Read of 4096 words -> four 1024-word bursts
        d0 = done_cnt; b0 = burst_cnt;
        push(1'b0, 48'h1000, 32'd4096, 4'd3);
        chk("t1_busy", 64'(busy), 64'd1);
        serve("t1_b0", 48'h1000, 32'd1024, 32'd0,    1'b0);
        serve("t1_b1", 48'h3000, 32'd1024, 32'd1024, 1'b0);
        serve("t1_b2", 48'h5000, 32'd1024, 32'd2048, 1'b0);
        serve("t1_b3", 48'h7000, 32'd1024, 32'd3072, 1'b0);
        chk("t1_done_now", 64'(done_valid), 64'd1);
        step(); step(); step();
        chk("t1_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("t1_bursts",   64'(burst_cnt - b0), 64'd4);
        chk_done("t1_done", 4'd3, 1'b0);
        chk("t1_idle", 64'(busy), 64'd0);

        // Write of 2500 words -> 1024 + 1024 + 452
        d0 = done_cnt; b0 = burst_cnt;
        push(1'b1, 48'h20_0000, 32'd2500, 4'd7);
        serve("t2_b0", 48'h20_0000, 32'd1024, 32'd0,    1'b1);
        serve("t2_b1", 48'h20_2000, 32'd1024, 32'd1024, 1'b1);
        serve("t2_b2", 48'h20_4000, 32'd452,  32'd2048, 1'b1);
        step(); step(); step();
        chk("t2_bursts",   64'(burst_cnt - b0), 64'd3);
        chk("t2_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk_done("t2_done", 4'd7, 1'b1);

        // Zero-length command: done in the third cycle after acceptance, no request
        d0 = done_cnt; b0 = burst_cnt;
        push(1'b0, 48'hABC0, 32'd0, 4'd5);
        chk("t3_cyc1_done", 64'(done_valid), 64'd0);
        step();
        chk("t3_cyc2_done", 64'(done_valid), 64'd0);
        step();
        chk("t3_cyc3_done", 64'(done_valid), 64'd1);
        chk("t3_cyc3_tag",  64'(done_tag),   64'd5);
        step();
        chk("t3_cyc4_done", 64'(done_valid), 64'd0);
        chk("t3_no_burst",  64'(burst_cnt - b0), 64'd0);
        chk("t3_done_cnt",  64'(done_cnt - d0), 64'd1);
        chk_done("t3_done", 4'd5, 1'b0);

        // Backpressure: acks withheld, six commands offered back to back
        d0 = done_cnt; a0 = acc_cnt;
        for (int k = 0; k < 5; k++)
            push(1'(k & 1), 48'(32'h1_0000 * (k + 1)), 32'd16, 4'(8 + k));
        chk("t4_ready_full", 64'(cmd_ready), 64'd0);
        chk("t4_acc5",       64'(acc_cnt - a0), 64'd5);
        cmd_rw = 1'b1; cmd_addr = 48'h6_0000; cmd_len = 32'd16; cmd_tag = 4'd13;
        cmd_valid = 1'b1;
        hold_target = a0 + 6;
        step(); step(); step();
        chk("t4_still_acc5", 64'(acc_cnt - a0), 64'd5);
        chk("t4_req_pending", 64'(mem_req), 64'd1);
        for (int k = 0; k < 6; k++)
            serve($sformatf("t4_c%0d", k), 48'(32'h1_0000 * (k + 1)), 32'd16, 32'd0, 1'(k & 1));
        hold_target = 0;
        cmd_valid = 1'b0;
        step(); step();
        chk("t4_acc6",     64'(acc_cnt - a0), 64'd6);
        chk("t4_done_cnt", 64'(done_cnt - d0), 64'd6);
        for (int k = 0; k < 6; k++)
            chk_done($sformatf("t4_order%0d", k), 4'(8 + k), 1'(k & 1));
        chk("t4_idle", 64'(busy), 64'd0);

        // Address wrap with MAX_BURST=256
        sel = 1'b1;
        step();
        d0 = done_cnt;
        push(1'b0, 48'hFFFF_FFFF_F000, 32'd1024, 4'd1);
        serve("t5_b0", 48'hFFFF_FFFF_F000, 32'd256, 32'd0,   1'b0);
        serve("t5_b1", 48'hFFFF_FFFF_F800, 32'd256, 32'd256, 1'b0);
        serve("t5_b2", 48'h0000_0000_0000, 32'd256, 32'd512, 1'b0);
        serve("t5_b3", 48'h0000_0000_0800, 32'd256, 32'd768, 1'b0);
        step();
        chk("t5_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk_done("t5_done", 4'd1, 1'b0);
        sel = 1'b0;
        step();

        // Reset in WAIT abandons the burst; next command runs cleanly
        push(1'b1, 48'h9000, 32'd2048, 4'd9);
        for (int i = 0; i < 20 && !mem_req; i++) step();
        chk("t6_in_wait", 64'(mem_req), 64'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_req",       64'(mem_req),    64'd0);
        chk("t6_rst_addr",      64'(mem_addr),   64'd0);
        chk("t6_rst_len",       64'(mem_len),    64'd0);
        chk("t6_rst_rw",        64'(mem_rw),     64'd0);
        chk("t6_rst_done_tag",  64'(done_tag),   64'd0);
        chk("t6_rst_done_rw",   64'(done_rw),    64'd0);
        chk("t6_rst_busy",      64'(busy),       64'd0);
        chk("t6_rst_ready",     64'(cmd_ready),  64'd1);
        step(); step();
        rst = 1'b0;
        d0 = done_cnt;
        step(); step(); step();
        chk("t6_no_stale_done", 64'(done_cnt - d0), 64'd0);
        push(1'b0, 48'h100, 32'd1024, 4'd2);
        serve("t6_b0", 48'h100, 32'd1024, 32'd0, 1'b0);
        step();
        chk("t6_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk_done("t6_done", 4'd2, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
